pll_lock_sequencer: RTL and testbench

- Controls the LCD pixel-clock rPLL from the 27 MHz board clock domain.
- Sequences the PLL reset and applies the dynamic divider selects (IDSEL/FBDSEL/ODSEL) on request.
- Qualifies LOCK and withholds `clk_good` from downstream video logic until lock is stable.
- Recovers from loss of lock. Bounds retries and reports a sticky failure.

---
 rtl/pll_lock_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: rPLL reset sequencing, divider select control and lock qualification.
// Ports: clk/rst_n; cfg_valid/cfg_ready + cfg_*sel reconfig request;
//        pll_lock in, pll_reset/pll_*sel out; clk_good, fail, retry_cnt status.
module pll_lock_sequencer #(
    parameter int         RESET_PULSE_CYCLES  = 16,
    parameter int         LOCK_TIMEOUT_CYCLES = 27000,
    parameter int         LOCK_STABLE_CYCLES  = 1024,
    parameter int         MAX_RETRIES         = 3,
    parameter logic [5:0] DEFAULT_IDSEL       = 6'd0,
    parameter logic [5:0] DEFAULT_FBDSEL      = 6'd0,
    parameter logic [5:0] DEFAULT_ODSEL       = 6'd0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [5:0]                           cfg_idsel,
    input  logic [5:0]                           cfg_fbdsel,
    input  logic [5:0]                           cfg_odsel,
    input  logic                                 pll_lock,
    output logic                                 pll_reset,
    output logic [5:0]                           pll_idsel,
    output logic [5:0]                           pll_fbdsel,
    output logic [5:0]                           pll_odsel,
    output logic                                 clk_good,
    output logic                                 fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int PW = $clog2(RESET_PULSE_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RESET_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUNNING,
        FAILED
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   rst_cnt, rst_cnt_n;
    logic [TW-1:0]   to_cnt, to_cnt_n;
    logic [SW-1:0]   st_cnt, st_cnt_n;
    logic            lock_meta, lock_s;

    logic            pll_reset_n, cfg_ready_n, clk_good_n, fail_n;
    logic [5:0]      idsel_n, fbdsel_n, odsel_n;
    logic [RW-1:0]   retry_n, retry_inc;

    logic            accept, timeout;
    logic            go_reset, go_timeout, go_accept;

    assign accept    = cfg_valid & cfg_ready;
    assign timeout   = (to_cnt == TO_LAST);
    assign retry_inc = retry_cnt + RW'(1);

    always_comb begin
        state_n     = state;
        rst_cnt_n   = rst_cnt;
        to_cnt_n    = to_cnt;
        st_cnt_n    = st_cnt;
        pll_reset_n = pll_reset;
        cfg_ready_n = cfg_ready;
        clk_good_n  = clk_good;
        fail_n      = fail;
        retry_n     = retry_cnt;
        idsel_n     = pll_idsel;
        fbdsel_n    = pll_fbdsel;
        odsel_n     = pll_odsel;
        go_reset    = 1'b0;
        go_timeout  = 1'b0;
        go_accept   = 1'b0;

        case (state)
            RESET_PLL: begin
                pll_reset_n = 1'b1;
                if (rst_cnt == PULSE_LAST) begin
                    state_n     = WAIT_LOCK;
                    rst_cnt_n   = '0;
                    to_cnt_n    = '0;
                    pll_reset_n = 1'b0;
                end else begin
                    rst_cnt_n = rst_cnt + PW'(1);
                end
            end
            WAIT_LOCK: begin
                // timeout takes priority over a lock arriving on the same edge
                if (timeout) begin
                    go_timeout = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TW'(1);
                    if (lock_s) begin
                        state_n  = STABILIZE;
                        st_cnt_n = '0;
                    end
                end
            end
            STABILIZE: begin
                if (timeout) begin
                    go_timeout = 1'b1;
                end else if (!lock_s) begin
                    // timeout keeps running so lock flicker cannot stall forever
                    state_n  = WAIT_LOCK;
                    st_cnt_n = '0;
                    to_cnt_n = to_cnt + TW'(1);
                end else if (st_cnt == STABLE_LAST) begin
                    state_n     = RUNNING;
                    clk_good_n  = 1'b1;
                    cfg_ready_n = 1'b1;
                end else begin
                    st_cnt_n = st_cnt + SW'(1);
                    to_cnt_n = to_cnt + TW'(1);
                end
            end
            RUNNING: begin
                if (accept) begin
                    go_accept = 1'b1;
                end else if (!lock_s) begin
                    go_reset = 1'b1;
                end
            end
            FAILED: begin
                if (accept) begin
                    go_accept = 1'b1;
                end
            end
            default: begin
                go_reset = 1'b1;
            end
        endcase

        if (go_timeout) begin
            retry_n = retry_inc;
            if (retry_inc == RETRY_MAX) begin
                state_n     = FAILED;
                fail_n      = 1'b1;
                pll_reset_n = 1'b1;
                cfg_ready_n = 1'b1;
                clk_good_n  = 1'b0;
            end else begin
                go_reset = 1'b1;
            end
        end

        if (go_accept) begin
            idsel_n  = cfg_idsel;
            fbdsel_n = cfg_fbdsel;
            odsel_n  = cfg_odsel;
            fail_n   = 1'b0;
            retry_n  = '0;
            go_reset = 1'b1;
        end

        if (go_reset) begin
            state_n     = RESET_PLL;
            rst_cnt_n   = '0;
            pll_reset_n = 1'b1;
            clk_good_n  = 1'b0;
            cfg_ready_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RESET_PLL;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            st_cnt     <= '0;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            pll_reset  <= 1'b1;
            pll_idsel  <= DEFAULT_IDSEL;
            pll_fbdsel <= DEFAULT_FBDSEL;
            pll_odsel  <= DEFAULT_ODSEL;
            cfg_ready  <= 1'b0;
            clk_good   <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_n;
            rst_cnt    <= rst_cnt_n;
            to_cnt     <= to_cnt_n;
            st_cnt     <= st_cnt_n;
            lock_meta  <= pll_lock;
            lock_s     <= lock_meta;
            pll_reset  <= pll_reset_n;
            pll_idsel  <= idsel_n;
            pll_fbdsel <= fbdsel_n;
            pll_odsel  <= odsel_n;
            cfg_ready  <= cfg_ready_n;
            clk_good   <= clk_good_n;
            fail       <= fail_n;
            retry_cnt  <= retry_n;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus random lock/cfg stimulus,
// every output compared each cycle against a behavioural model of the sequencer.
module tb_pll_lock_sequencer;

    localparam int P   = 4;
    localparam int T   = 32;
    localparam int S   = 8;
    localparam int MAX = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       clk_good;
    logic       fail;
    logic [1:0] retry_cnt;

    pll_lock_sequencer #(
        .RESET_PULSE_CYCLES (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES (S),
        .MAX_RETRIES        (MAX),
        .DEFAULT_IDSEL      (6'd0),
        .DEFAULT_FBDSEL     (6'd0),
        .DEFAULT_ODSEL      (6'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .clk_good  (clk_good),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            if (n_fails <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // behavioural model: acquisition is one phase tracked by attempt age and
    // the length of the current run of synchronized lock samples
    localparam int PH_PULSE = 0;
    localparam int PH_ACQ   = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_FAIL  = 3;

    int m_phase, m_pulse, m_age, m_run, m_retry;
    int m_id, m_fb, m_od;
    int m_reset, m_ready, m_good, m_fail;
    int m_s1, m_s2;

    task automatic m_start_pulse();
        m_phase = PH_PULSE;
        m_pulse = 0;
        m_reset = 1;
        m_good  = 0;
        m_ready = 0;
    endtask

    task automatic model_step();
        int  l;
        bit  acc;
        if (!rst_n) begin
            m_start_pulse();
            m_age = 0; m_run = 0; m_retry = 0;
            m_id = 0; m_fb = 0; m_od = 0;
            m_fail = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        l    = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(pll_lock);
        acc  = cfg_valid && (m_ready == 1);
        case (m_phase)
            PH_PULSE: begin
                m_pulse++;
                if (m_pulse == P) begin
                    m_phase = PH_ACQ;
                    m_age = 0; m_run = 0; m_reset = 0;
                end
            end
            PH_ACQ: begin
                m_age++;
                if (m_age == T) begin
                    m_retry++;
                    if (m_retry == MAX) begin
                        m_phase = PH_FAIL;
                        m_fail = 1; m_reset = 1; m_ready = 1; m_good = 0;
                    end else begin
                        m_start_pulse();
                    end
                end else begin
                    m_run = (l != 0) ? m_run + 1 : 0;
                    if (m_run == S + 1) begin
                        m_phase = PH_RUN;
                        m_good = 1; m_ready = 1;
                    end
                end
            end
            default: begin
                if (acc) begin
                    m_id = int'(cfg_idsel); m_fb = int'(cfg_fbdsel); m_od = int'(cfg_odsel);
                    m_fail = 0; m_retry = 0;
                    m_start_pulse();
                end else if (m_phase == PH_RUN && l == 0) begin
                    m_start_pulse();
                end
            end
        endcase
    endtask

    // stimulus side: PLL lock behaviour relative to the fall of pll_reset
    int lock_mode  = 0;
    int since_fall = 0;
    int force_low  = 0;
    bit rand_on    = 0;

    task automatic drive();
        bit lk;
        if (pll_reset === 1'b0) since_fall++;
        else since_fall = 0;
        case (lock_mode)
            1: lk = (since_fall >= 10);
            2: lk = (since_fall >= 10) && (since_fall != 15);
            3: lk = (since_fall >= 1) && ((since_fall % 6) != 0);
            4: lk = (since_fall >= 6) && ($urandom_range(0, 24) != 0);
            default: lk = 1'b0;
        endcase
        if (force_low > 0) begin
            lk = 1'b0;
            force_low--;
        end
        pll_lock = lk;
        if (rand_on) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_idsel  = 6'($urandom_range(0, 63));
            cfg_fbdsel = 6'($urandom_range(0, 63));
            cfg_odsel  = 6'($urandom_range(0, 63));
        end
    endtask

    int cyc = 0;
    int lock_seen = -1;
    int rise_cyc = -1, fall_cyc = -1;
    int hi_run = 0, lo_run = 0, last_pulse = -1, last_low = -1;
    bit good_prev = 0;

    task automatic step();
        bit rst_edge;
        drive();
        @(posedge clk);
        cyc++;
        rst_edge = !rst_n;
        if (pll_lock) begin
            if (lock_seen < 0) lock_seen = cyc;
        end else begin
            lock_seen = -1;
        end
        model_step();
        @(negedge clk);
        chk("pll_reset", int'(pll_reset), m_reset);
        chk("cfg_ready", int'(cfg_ready), m_ready);
        chk("clk_good",  int'(clk_good),  m_good);
        chk("fail",      int'(fail),      m_fail);
        chk("retry_cnt", int'(retry_cnt), m_retry);
        chk("pll_idsel", int'(pll_idsel), m_id);
        chk("pll_fbdsel", int'(pll_fbdsel), m_fb);
        chk("pll_odsel", int'(pll_odsel), m_od);
        if (!good_prev && clk_good) rise_cyc = cyc;
        if (good_prev && !clk_good) fall_cyc = cyc;
        good_prev = clk_good;
        if (rst_edge) hi_run = 0;
        if (pll_reset) begin
            hi_run++;
            if (lo_run > 0) last_low = lo_run;
            lo_run = 0;
        end else begin
            lo_run++;
            if (hi_run > 0) last_pulse = hi_run;
            hi_run = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_good(input string tag, input int bound);
        int k;
        k = 0;
        while (k < bound && clk_good !== 1'b1) begin
            step();
            k++;
        end
        chk(tag, int'(clk_good === 1'b1), 1);
    endtask

    task automatic send_cfg(input int id, input int fb, input int od);
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'(id);
        cfg_fbdsel = 6'(fb);
        cfg_odsel  = 6'(od);
        step();
        cfg_valid = 1'b0;
    endtask

    int drop_cyc;

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0;
        cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
        pll_lock = 1'b0;
        @(negedge clk);
        run(3);
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_clk_good", int'(clk_good), 0);

        // clean bring-up
        lock_mode = 1;
        rst_n = 1'b1;
        run_until_good("bringup_good", 100);
        chk("bringup_pulse", last_pulse, P);
        chk("bringup_latency", rise_cyc - lock_seen, S + 2);
        chk("bringup_ready", int'(cfg_ready), 1);
        chk("bringup_retry", int'(retry_cnt), 0);

        // lock loss in RUNNING
        run(5);
        force_low = 3;
        drop_cyc = cyc + 1;
        run(4);
        chk("loss_fall_delay", fall_cyc - drop_cyc + 1, 3);
        run_until_good("relock_good", 100);
        chk("loss_pulse", last_pulse, P);
        chk("loss_retry", int'(retry_cnt), 0);
        chk("relock_latency", rise_cyc - lock_seen, S + 2);

        // reconfiguration from RUNNING, then flicker once during acquisition
        run(3);
        send_cfg(8, 31, 8);
        chk("cfg_idsel", int'(pll_idsel), 8);
        chk("cfg_fbdsel", int'(pll_fbdsel), 31);
        chk("cfg_odsel", int'(pll_odsel), 8);
        chk("cfg_reset", int'(pll_reset), 1);
        chk("cfg_ready_low", int'(cfg_ready), 0);
        lock_mode = 2;
        run_until_good("flicker_good", 100);
        chk("flicker_latency", rise_cyc - lock_seen, S + 2);

        // repeated flicker: every attempt times out
        lock_mode = 3;
        run(60);
        chk("flicker6_window", last_low, T);
        chk("flicker6_retry", int'(retry_cnt), 1);

        // lock never arrives: timeouts exhaust retries
        lock_mode = 0;
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2 * (P + T) + 6);
        chk("to_window", last_low, T);
        chk("to_fail", int'(fail), 1);
        chk("to_reset", int'(pll_reset), 1);
        chk("to_ready", int'(cfg_ready), 1);
        chk("to_good", int'(clk_good), 0);
        chk("to_retry", int'(retry_cnt), MAX);

        // accept from FAILED clears status
        send_cfg(5, 17, 3);
        chk("fcfg_fail", int'(fail), 0);
        chk("fcfg_retry", int'(retry_cnt), 0);
        chk("fcfg_idsel", int'(pll_idsel), 5);
        lock_mode = 1;
        run_until_good("fcfg_good", 100);

        // reset during STABILIZE after a reconfiguration
        send_cfg(8, 31, 8);
        run(P + 13);
        rst_n = 1'b0;
        run(1);
        chk("mrst_idsel", int'(pll_idsel), 0);
        chk("mrst_fbdsel", int'(pll_fbdsel), 0);
        chk("mrst_odsel", int'(pll_odsel), 0);
        chk("mrst_reset", int'(pll_reset), 1);
        chk("mrst_good", int'(clk_good), 0);
        rst_n = 1'b1;
        run(5);

        // random lock behaviour, cfg requests and occasional resets
        lock_mode = 4;
        rand_on = 1'b1;
        run(1500);
        rand_on = 1'b0;
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
